// File: rtl/synth_pkg.sv
// synth_pkg: shared RAM map, bus widths and arbiter state encoding
package synth_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int VOLUME = 0;
  localparam int FILTER_CHOICE = 1;
  localparam int OSC_CHOICE = 2;
  localparam int SETTINGS_MENU = 3;
  localparam int NOTE_ON_START = 4;
  localparam int NOTE_PHASE_START = 28;
  localparam int OUT_HISTORY_START = 52;
  localparam int OUT_HISTORY_LEN = 160;
  typedef enum logic {ARB_NORMAL = 1'b0, ARB_FORCE = 1'b1} arb_state_e;
endpackage

// File: rtl/param_ram_bypass.sv
// param_ram_bypass: write-first forwarding of same-cycle write data onto the read return
module param_ram_bypass
  import synth_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] rdata
);
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] data_q, data_d;
  // flag a read that collides with this cycle's write and capture the write data
  always_comb begin
    hit_d = rd_en & wen & (rd_addr == waddr);
    data_d = wdata;
  end
  // register the compare result alongside the RAM's one-cycle read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
      data_q <= '0;
    end else begin
      hit_q <= hit_d;
      data_q <= data_d;
    end
  end
  assign rdata = hit_q ? data_q : ram_dout;
endmodule

// File: rtl/param_ram_arbiter.sv
// param_ram_arbiter: shared parameter RAM read port arbiter with display starvation guard
module param_ram_arbiter
  import synth_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_ren,
  input  logic [ADDR_W-1:0] p_raddr,
  input  logic              p_wen,
  input  logic [ADDR_W-1:0] p_waddr,
  input  logic [DATA_W-1:0] p_din,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_dout,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_raddr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_dout,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_din
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  arb_state_e        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              owner_q, owner_d, valid_q, valid_d;
  logic [DATA_W-1:0] p_dout_q, p_dout_d, d_dout_q, d_dout_d;
  logic              force_slot, p_gnt;
  logic [DATA_W-1:0] rdata;
  assign ram_we = p_wen;
  assign ram_waddr = p_waddr;
  assign ram_din = p_din;
  // grant decision, starvation counting and next state; grants are held off during reset
  always_comb begin
    force_slot = state_q == ARB_FORCE;
    p_gnt = rst_n & p_ren & ~force_slot;
    d_gnt = rst_n & d_req & (force_slot | ~p_ren);
    p_stall = rst_n & force_slot & p_ren;
    ram_raddr = p_gnt ? p_raddr : d_gnt ? d_raddr : '0;
    wait_cnt_d = (d_gnt | ~d_req) ? 4'd0 : (wait_cnt_q >= LIMIT) ? LIMIT : 4'(wait_cnt_q + 4'd1);
    state_d = (!force_slot && d_req && !d_gnt && wait_cnt_d == LIMIT) ? ARB_FORCE : ARB_NORMAL;
    valid_d = p_gnt | d_gnt;
    owner_d = d_gnt;
    p_rvalid = valid_q & ~owner_q;
    d_rvalid = valid_q & owner_q;
    p_dout = p_rvalid ? rdata : p_dout_q;
    d_dout = d_rvalid ? rdata : d_dout_q;
    p_dout_d = p_dout;
    d_dout_d = d_dout;
  end
  // state, in-flight read tracking and held read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_NORMAL;
      wait_cnt_q <= 4'd0;
      owner_q <= 1'b0;
      valid_q <= 1'b0;
      p_dout_q <= '0;
      d_dout_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      p_dout_q <= p_dout_d;
      d_dout_q <= d_dout_d;
    end
  end
  param_ram_bypass u_bypass (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (p_gnt | d_gnt),
    .rd_addr (ram_raddr),
    .wen     (p_wen),
    .waddr   (p_waddr),
    .wdata   (p_din),
    .ram_dout(ram_dout),
    .rdata   (rdata)
  );
endmodule

// File: tb/tb_param_ram_arbiter.sv
// tb_param_ram_arbiter: table-driven and sequence checks of the parameter RAM arbiter
module tb_param_ram_arbiter;
  import synth_pkg::*;
  logic        clk = 0, rst_n = 0;
  logic        p_ren = 0, p_wen = 0, d_req = 0;
  logic [7:0]  p_raddr = 0, p_waddr = 0, d_raddr = 0;
  logic [31:0] p_din = 0;
  logic        p_stall, p_rvalid, d_gnt, d_rvalid, ram_we;
  logic [31:0] p_dout, d_dout, ram_din, ram_dout;
  logic [7:0]  ram_raddr, ram_waddr;
  logic [31:0] mem [256];
  int          passed = 0, total = 0;

  param_ram_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .p_ren(p_ren), .p_raddr(p_raddr), .p_wen(p_wen),
    .p_waddr(p_waddr), .p_din(p_din), .p_stall(p_stall), .p_rvalid(p_rvalid),
    .p_dout(p_dout), .d_req(d_req), .d_raddr(d_raddr), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_dout(d_dout), .ram_raddr(ram_raddr), .ram_dout(ram_dout),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // synchronous RAM, read-before-write, contents restored during reset
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 3) ? 32'd2 : 32'h100 + 32'(i);
    end else if (ram_we) mem[ram_waddr] <= ram_din;
    ram_dout <= mem[ram_raddr];
  end

  typedef struct {
    logic        p_ren;
    logic [7:0]  p_raddr;
    logic        p_wen;
    logic [7:0]  p_waddr;
    logic [31:0] p_din;
    logic        d_req;
    logic [7:0]  d_raddr;
    logic        e_stall;
    logic        e_gnt;
    logic        e_prv;
    logic [31:0] e_pdout;
    logic        e_drv;
    logic [31:0] e_ddout;
    logic [7:0]  e_raddr;
  } vec_t;
  vec_t vec [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic run_contention(input logic [7:0] da, input logic [31:0] ed);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      p_ren = 1; p_raddr = 3; p_wen = 0; d_raddr = da; d_req = (k < 10);
      @(negedge clk);
      chk("cont_gnt", {31'd0, d_gnt}, {31'd0, k == 9});
      chk("cont_stall", {31'd0, p_stall}, {31'd0, k == 9});
      chk("cont_drv", {31'd0, d_rvalid}, {31'd0, k == 10});
      chk("cont_raddr", {24'd0, ram_raddr}, (k == 9) ? {24'd0, da} : 32'd3);
      if (k > 1) chk("cont_prv", {31'd0, p_rvalid}, {31'd0, k != 10});
      if (k == 10) chk("cont_ddout", d_dout, ed);
    end
  endtask

  initial begin
    vec[0]  = '{0, 0, 0, 0, 0,       0, 0,   0, 0, 0, 0,      0, 0,      0};
    vec[1]  = '{1, 3, 0, 0, 0,       0, 0,   0, 0, 0, 0,      0, 0,      3};
    vec[2]  = '{0, 0, 0, 0, 0,       0, 0,   0, 0, 1, 2,      0, 0,      0};
    vec[3]  = '{0, 0, 0, 0, 0,       0, 0,   0, 0, 0, 2,      0, 0,      0};
    vec[4]  = '{0, 0, 0, 0, 0,       1, 100, 0, 1, 0, 2,      0, 0,      100};
    vec[5]  = '{0, 0, 0, 0, 0,       0, 0,   0, 0, 0, 2,      1, 'h164,  0};
    vec[6]  = '{1, 1, 1, 1, 1,       0, 0,   0, 0, 0, 2,      0, 'h164,  1};
    vec[7]  = '{0, 0, 0, 0, 0,       0, 0,   0, 0, 1, 1,      0, 'h164,  0};
    vec[8]  = '{1, 2, 1, 5, 'hdead,  0, 0,   0, 0, 0, 1,      0, 'h164,  2};
    vec[9]  = '{0, 0, 0, 0, 0,       0, 0,   0, 0, 1, 'h102,  0, 'h164,  0};
    vec[10] = '{0, 0, 0, 0, 0,       1, 5,   0, 1, 0, 'h102,  0, 'h164,  5};
    vec[11] = '{0, 0, 0, 0, 0,       0, 0,   0, 0, 0, 'h102,  1, 'hdead, 0};
    vec[12] = '{0, 0, 1, 7, 'h77,    1, 7,   0, 1, 0, 'h102,  0, 'hdead, 7};
    vec[13] = '{0, 0, 0, 0, 0,       0, 0,   0, 0, 0, 'h102,  1, 'h77,   0};
    vec[14] = '{1, 1, 0, 0, 0,       1, 52,  0, 0, 0, 'h102,  0, 'h77,   1};
    vec[15] = '{0, 0, 0, 0, 0,       0, 0,   0, 0, 1, 1,      0, 'h77,   0};

    d_req = 1; d_raddr = 9; p_ren = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {31'd0, d_gnt}, 0);
    chk("rst_stall", {31'd0, p_stall}, 0);
    chk("rst_prv", {31'd0, p_rvalid}, 0);
    chk("rst_drv", {31'd0, d_rvalid}, 0);
    chk("rst_pdout", p_dout, 0);
    chk("rst_ddout", d_dout, 0);
    d_req = 0; p_ren = 0;
    @(posedge clk); #1 rst_n = 1;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      p_ren = vec[i].p_ren; p_raddr = vec[i].p_raddr; p_wen = vec[i].p_wen;
      p_waddr = vec[i].p_waddr; p_din = vec[i].p_din; d_req = vec[i].d_req; d_raddr = vec[i].d_raddr;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), {31'd0, p_stall}, {31'd0, vec[i].e_stall});
      chk($sformatf("v%0d_gnt", i), {31'd0, d_gnt}, {31'd0, vec[i].e_gnt});
      chk($sformatf("v%0d_prv", i), {31'd0, p_rvalid}, {31'd0, vec[i].e_prv});
      chk($sformatf("v%0d_pdout", i), p_dout, vec[i].e_pdout);
      chk($sformatf("v%0d_drv", i), {31'd0, d_rvalid}, {31'd0, vec[i].e_drv});
      chk($sformatf("v%0d_ddout", i), d_dout, vec[i].e_ddout);
      chk($sformatf("v%0d_raddr", i), {24'd0, ram_raddr}, {24'd0, vec[i].e_raddr});
    end

    run_contention(52, 'h134);

    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1 p_ren = 1; d_req = 1; d_raddr = 60;
      @(negedge clk);
      chk("wd_gnt", {31'd0, d_gnt}, 0);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 d_req = 0;
      @(negedge clk);
      chk("wd_stall", {31'd0, p_stall}, 0);
      if (k > 0) chk("wd_wait", {28'd0, dut.wait_cnt_q}, 0);
      if (k > 0) chk("wd_state", {31'd0, dut.state_q}, {31'd0, ARB_NORMAL});
    end
    run_contention(60, 'h13c);

    @(posedge clk); #1 p_ren = 0; d_req = 1; d_raddr = 100;
    @(negedge clk);
    chk("idle_gnt", {31'd0, d_gnt}, 1);
    chk("idle_wait", {28'd0, dut.wait_cnt_q}, 0);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mid_drv", {31'd0, d_rvalid}, 0);
    chk("mid_gnt", {31'd0, d_gnt}, 0);
    chk("mid_state", {31'd0, dut.state_q}, {31'd0, ARB_NORMAL});
    chk("mid_pdout", p_dout, 0);
    chk("mid_ddout", d_dout, 0);
    d_req = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("post_drv", {31'd0, d_rvalid}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/param_ram_arbiter.md
PARAM_RAM_ARBITER -- requirements
Module: param_ram_arbiter

Interface
REQ-001 SHALL expose: clk  input  1  system clock (50 MHz); all logic on posedge.
REQ-002 SHALL expose: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL expose: p_ren  input  1  processor read request, one word per cycle.
REQ-004 SHALL expose: p_raddr  input  8  processor read address.
REQ-005 SHALL expose: p_wen  input  1  processor write strobe.
REQ-006 SHALL expose: p_waddr  input  8  processor write address.
REQ-007 SHALL expose: p_din  input  32  processor write data.
REQ-008 SHALL expose: p_stall  output  1  processor read not accepted this cycle; the processor holds p_ren and p_raddr.
REQ-009 SHALL expose: p_rvalid  output  1  p_dout valid.
REQ-010 SHALL expose: p_dout  output  32  processor read data.
REQ-011 SHALL expose: d_req  input  1  display read request; held with d_raddr stable until d_gnt.
REQ-012 SHALL expose: d_raddr  input  8  display read address (parameter or out-history region).
REQ-013 SHALL expose: d_gnt  output  1  display request accepted this cycle.
REQ-014 SHALL expose: d_rvalid  output  1  d_dout valid.
REQ-015 SHALL expose: d_dout  output  32  display read data.
REQ-016 SHALL expose: ram_raddr  output  8  shared RAM read address; ram_dout is valid one cycle later.
REQ-017 SHALL expose: ram_dout  input  32  shared RAM read data.
REQ-018 SHALL expose: ram_we  output  1  RAM write enable.
REQ-019 SHALL expose: ram_waddr  output  8  RAM write address.
REQ-020 SHALL expose: ram_din  output  32  RAM write data.
REQ-021 SHALL expose: parameter STARVE_LIMIT, default 8, consecutive display-denied cycles before forced display grant.

Function
REQ-022 Write path SHALL be unarbitrated: ram_we=p_wen, ram_waddr=p_waddr, ram_din=p_din, all combinational.
REQ-023 The read port SHALL run a two-state FSM, ARB_NORMAL and ARB_FORCE.
REQ-024 In ARB_NORMAL the read port SHALL behave as follows:
- p_ren=1: processor is granted.
- p_ren=1 and d_req=1: display is denied, wait_cnt increments.
- p_ren=0 and d_req=1: d_gnt=1.
REQ-025 wait_cnt SHALL be 4 bits, SHALL reset to 0 on any d_gnt, and SHALL saturate at STARVE_LIMIT.
REQ-026 When wait_cnt reaches STARVE_LIMIT with d_req=1, the FSM SHALL enter ARB_FORCE on the next cycle.
REQ-027 In ARB_FORCE: d_gnt=1, p_stall=p_ren, FSM returns to ARB_NORMAL on the next cycle (exactly one forced slot).
REQ-028 p_stall SHALL be asserted only in ARB_FORCE.
REQ-029 ram_raddr SHALL be p_raddr when the processor is granted, d_raddr when the display is granted, else 0.
REQ-030 A 1-bit owner register SHALL record the granted requester, and a valid bit SHALL record that a read issued; both route ram_dout one cycle later.
REQ-031 Read latency SHALL be exactly 1 cycle: p_rvalid or d_rvalid is asserted in the cycle after the grant, and both are never asserted together.
REQ-032 p_dout and d_dout SHALL hold their last valid value until the next valid read for that port.
REQ-033 Write-first bypass: if a read is granted in the same cycle that p_wen writes the same address, the returned data SHALL be that cycle's p_din, not ram_dout.
REQ-034 d_req dropped without d_gnt SHALL be legal, SHALL clear wait_cnt, and SHALL return ARB_FORCE to ARB_NORMAL without granting.

Reset
REQ-035 While rst_n=0 at a clock edge, the block SHALL reset to:
- FSM ARB_NORMAL, wait_cnt 0, owner 0, valid 0.
- p_rvalid 0, d_rvalid 0, p_dout 0, d_dout 0.
REQ-036 A read in flight when reset asserts SHALL be discarded: no rvalid after reset.
REQ-037 Combinational outputs SHALL follow inputs during reset; d_gnt and p_stall SHALL be 0 during reset.

Structure
REQ-038 Package synth_pkg SHALL hold:
- RAM map constants: VOLUME 0, FILTER_CHOICE 1, OSC_CHOICE 2, SETTINGS_MENU 3, NOTE_ON_START 4, NOTE_PHASE_START 28, OUT_HISTORY_START 52, OUT_HISTORY_LEN 160.
- Data width 32 and address width 8.
- The arbiter state encoding.
REQ-039 Write-first forwarding SHALL be one sub-module, param_ram_bypass (registered address compare plus data mux).

Verification
REQ-040 Processor only: p_ren with p_raddr=3, RAM[3]=2 -> p_rvalid next cycle, p_dout=2, p_stall never high.
REQ-041 Contention: p_ren held high, d_req with d_raddr=52 -> d_gnt on cycle 9 after d_req, p_stall=1 that cycle only, d_rvalid with RAM[52] on cycle 10.
REQ-042 Idle processor: d_req with d_raddr=100 -> d_gnt same cycle, d_rvalid next cycle, wait_cnt 0.
REQ-043 Bypass: p_wen to address 1 with p_din=1 while p_ren reads address 1 -> p_dout=1.
REQ-044 Reset mid-read: grant to display, rst_n=0 on the next edge -> d_rvalid stays 0, FSM ARB_NORMAL, outputs 0.
REQ-045 Withdrawn request: d_req high for 5 denied cycles then low -> wait_cnt=0, no d_gnt, no forced slot.
